// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage: the instruction bundle
// handed over from execute, the funct3 load/store encodings, and small
// helpers for lane selection and byte-enable generation.
package riscv_pkg;

  // funct3 encodings for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 encodings for stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0] for both loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [2:0] f3;
    logic       is_load;
    logic       is_store;
    logic       reg_we;
    logic [4:0] rd;
  } instruction_t;

  // Halfwords must sit on even bytes, words on word boundaries
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Clear whichever low address bits an access of this size may not use
  function automatic logic [1:0] aligned_offset(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store datum across every lane so the byte enables alone
  // decide which bytes land in memory
  function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/memstage_load_align.sv
// Load formatter: picks the addressed lane out of the read word and
// sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  // Extend the selected lane to a full register value
  always_comb begin
    case (f3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data = {24'h0, lane[7:0]};
      F3_LHU:  data = {16'h0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// Memory stage: passes ALU results straight to writeback, or runs one
// data-memory access (request held until ack, aborted after DMEM_TIMEOUT
// wait cycles) and returns the formatted load result.
// Optional: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently aligning them.
module memstage
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  instruction_t instruction_i,
  input  logic [31:0]  result_i,
  input  logic [31:0]  store_data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [31:0]  dmem_addr_o,
  output logic [31:0]  dmem_wdata_o,
  output logic [3:0]   dmem_be_o,
  input  logic         dmem_ack_i,
  input  logic [31:0]  dmem_rdata_i,
  output logic         wb_valid_o,
  output logic         wb_we_o,
  output logic [4:0]   wb_rd_o,
  output logic [31:0]  wb_data_o,
  output logic         error_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Last wait cycle index; reaching it without ack aborts the access
  localparam logic [7:0] TMO_LAST = 8'(DMEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept, mem_op, trap;
  logic [1:0]  size, offset;
  logic        complete, timeout, respond;

  // Details of the access in flight, needed when the response arrives
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [4:0]  lat_rd;
  logic        lat_we, lat_load;
  logic [31:0] load_data;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i & ready_o;
  assign mem_op  = instruction_i.is_load | instruction_i.is_store;
  assign size    = instruction_i.f3[1:0];

`ifdef MISALIGN_TRAP_EN
  assign trap   = mem_op & is_misaligned(size, result_i[1:0]);
  assign offset = result_i[1:0];
`else
  assign trap   = 1'b0;
  assign offset = aligned_offset(size, result_i[1:0]);
`endif

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (lat_off),
    .f3     (lat_f3),
    .data   (load_data)
  );

  // State and wait-counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counting and completion events
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    timeout  = 1'b0;
    respond  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && mem_op) begin
          state_d = trap ? RESP : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        respond = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request, writeback bundle and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      error_o      <= 1'b0;
      lat_f3       <= '0;
      lat_off      <= '0;
      lat_rd       <= '0;
      lat_we       <= 1'b0;
      lat_load     <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      error_o    <= 1'b0;

      if (accept) begin
        if (!mem_op) begin
          wb_valid_o <= 1'b1;
          wb_we_o    <= instruction_i.reg_we;
          wb_rd_o    <= instruction_i.rd;
          wb_data_o  <= result_i;
        end else begin
          lat_f3   <= instruction_i.f3;
          lat_off  <= offset;
          lat_rd   <= instruction_i.rd;
          lat_we   <= instruction_i.reg_we;
          lat_load <= instruction_i.is_load;
          if (!trap) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= instruction_i.is_store;
            dmem_addr_o  <= {result_i[31:2], 2'b00};
            dmem_be_o    <= byte_enable(size, offset);
            dmem_wdata_o <= store_lanes(size, store_data_i);
          end
        end
      end

      if (complete) begin
        dmem_req_o <= 1'b0;
        wb_valid_o <= 1'b1;
        wb_we_o    <= lat_load & lat_we;
        wb_rd_o    <= lat_rd;
        wb_data_o  <= lat_load ? load_data : 32'h0;
      end

      if (timeout || respond) begin
        dmem_req_o <= 1'b0;
        error_o    <= 1'b1;
        wb_valid_o <= 1'b1;
        wb_we_o    <= 1'b0;
        wb_rd_o    <= lat_rd;
        wb_data_o  <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_memstage.sv
// Testbench for memstage: directed vectors with a writeback scoreboard.
// Stimulus pushes the expected writeback into a queue; a monitor pops and
// compares whenever wb_valid_o is presented.
module tb_memstage;
  import riscv_pkg::*;

  localparam int unsigned TMO = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  instruction_t instruction_i;
  logic [31:0]  result_i, store_data_i, dmem_rdata_i;
  logic         valid_i, dmem_ack_i;
  logic         ready_o, dmem_req_o, dmem_we_o;
  logic [31:0]  dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]   dmem_be_o;
  logic         wb_valid_o, wb_we_o, error_o;
  logic [4:0]   wb_rd_o;

  memstage #(.DMEM_TIMEOUT(TMO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instruction_i (instruction_i),
    .result_i      (result_i),
    .store_data_i  (store_data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_ack_i    (dmem_ack_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk_rd_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_wb(logic we, logic [4:0] rd, logic [31:0] data, logic err, logic chk);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err; e.chk_rd_data = chk;
    exp_q.push_back(e);
  endtask

  function automatic instruction_t mk(logic [2:0] f3, logic ld, logic st, logic we, logic [4:0] rd);
    instruction_t i;
    i.f3 = f3; i.is_load = ld; i.is_store = st; i.reg_we = we; i.rd = rd;
    return i;
  endfunction

  // Monitor: every writeback must match the oldest expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (wb_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid_o=1, want no writeback at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("wb_we", 32'(wb_we_o), 32'(e.we));
        check("wb_err", 32'(error_o), 32'(e.err));
        if (e.chk_rd_data) begin
          check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
          check("wb_data", wb_data_o, e.data);
        end
      end
    end else begin
      check("stray_error", 32'(error_o), 32'd0);
    end
  end

  // Wait for ready, then present one instruction for a single cycle
  task automatic send(instruction_t ins, logic [31:0] res, logic [31:0] sd);
    int n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got ready_o=0 after %0d cycles, want 1", n);
    end
    instruction_i = ins;
    result_i      = res;
    store_data_i  = sd;
    valid_i       = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  // One memory access; ack_cyc = wait cycle carrying ack, 0 = never ack
  task automatic mem_op(string nm, logic [2:0] f3, logic st, logic [4:0] rd,
                        logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                        int ack_cyc, logic [31:0] exp_addr, logic [3:0] exp_be,
                        logic [31:0] exp_wdata);
    int limit;
    limit = (ack_cyc == 0) ? int'(TMO) : ack_cyc;
    send(mk(f3, !st, st, !st, rd), addr, sdata);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk_i);
      check({nm, "_req"}, 32'(dmem_req_o), 32'd1);
      check({nm, "_addr"}, dmem_addr_o, exp_addr);
      check({nm, "_be"}, 32'(dmem_be_o), 32'(exp_be));
      if (c == 1) begin
        check({nm, "_we"}, 32'(dmem_we_o), 32'(st));
        check({nm, "_busy"}, 32'(ready_o), 32'd0);
        if (st) check({nm, "_wdata"}, dmem_wdata_o, exp_wdata);
      end
      if (c == ack_cyc) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      @(posedge clk_i);
      #1 dmem_ack_i = 1'b0;
    end
    @(negedge clk_i);
    check({nm, "_req_drop"}, 32'(dmem_req_o), 32'd0);
    check({nm, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    rst_i         = 1'b1;
    valid_i       = 1'b0;
    dmem_ack_i    = 1'b0;
    dmem_rdata_i  = '0;
    result_i      = '0;
    store_data_i  = '0;
    instruction_i = mk(3'b000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset state
    #3;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_be", 32'(dmem_be_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ADD: single-cycle passthrough
    expect_wb(1'b1, 5'd3, 32'h0000_0005, 1'b0, 1'b1);
    send(mk(3'b000, 1'b0, 1'b0, 1'b1, 5'd3), 32'h0000_0005, 32'h0);
    @(negedge clk_i);
    check("add_no_req", 32'(dmem_req_o), 32'd0);
    check("add_ready", 32'(ready_o), 32'd1);

    // Stores
    expect_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    mem_op("sb", F3_SB, 1'b1, 5'd0, 32'h0000_0103, 32'h1234_56AB, 32'h0, 3,
           32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    expect_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    mem_op("sh", F3_SH, 1'b1, 5'd0, 32'h0000_0202, 32'h5555_BEEF, 32'h0, 1,
           32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    expect_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    mem_op("sw", F3_SW, 1'b1, 5'd0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 2,
           32'h0000_0300, 4'b1111, 32'hDEAD_BEEF);

    // Loads
    expect_wb(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b1);
    mem_op("lb", F3_LB, 1'b0, 5'd5, 32'h0000_0102, 32'h0, 32'h0080_FF00, 2,
           32'h0000_0100, 4'b0100, 32'h0);
    expect_wb(1'b1, 5'd6, 32'h0000_0080, 1'b0, 1'b1);
    mem_op("lbu", F3_LBU, 1'b0, 5'd6, 32'h0000_0102, 32'h0, 32'h0080_FF00, 1,
           32'h0000_0100, 4'b0100, 32'h0);
    expect_wb(1'b1, 5'd7, 32'hFFFF_8001, 1'b0, 1'b1);
    mem_op("lh", F3_LH, 1'b0, 5'd7, 32'h0000_0012, 32'h0, 32'h8001_7777, 1,
           32'h0000_0010, 4'b1100, 32'h0);
    expect_wb(1'b1, 5'd8, 32'h0000_F00D, 1'b0, 1'b1);
    mem_op("lhu", F3_LHU, 1'b0, 5'd8, 32'h0000_0020, 32'h0, 32'h1234_F00D, 1,
           32'h0000_0020, 4'b0011, 32'h0);
    expect_wb(1'b1, 5'd9, 32'hCAFE_BABE, 1'b0, 1'b1);
    mem_op("lw", F3_LW, 1'b0, 5'd9, 32'h0000_0400, 32'h0, 32'hCAFE_BABE, 1,
           32'h0000_0400, 4'b1111, 32'h0);

    // Timeout: no ack for TMO cycles
    expect_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    mem_op("lw_tmo", F3_LW, 1'b0, 5'd10, 32'h0000_0500, 32'h0, 32'h0, 0,
           32'h0000_0500, 4'b1111, 32'h0);

    // Ack in the same cycle as the timeout wins
    expect_wb(1'b1, 5'd11, 32'h0BAD_F00D, 1'b0, 1'b1);
    mem_op("lw_late", F3_LW, 1'b0, 5'd11, 32'h0000_0504, 32'h0, 32'h0BAD_F00D, 4,
           32'h0000_0504, 4'b1111, 32'h0);

    // Reset mid-WAIT discards the access
    send(mk(F3_LW, 1'b1, 1'b0, 1'b1, 5'd12), 32'h0000_0600, 32'h0);
    @(negedge clk_i);
    check("rstw_req_before", 32'(dmem_req_o), 32'd1);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("rstw_req_async", 32'(dmem_req_o), 32'd0);
    check("rstw_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1 dmem_ack_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rstw_req_after", 32'(dmem_req_o), 32'd0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word traps: no request, error after the RESP cycle
    expect_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    send(mk(F3_LW, 1'b1, 1'b0, 1'b1, 5'd13), 32'h0000_0102, 32'h0);
    @(negedge clk_i);
    check("mis_lw_no_req", 32'(dmem_req_o), 32'd0);
    check("mis_lw_busy", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check("mis_lw_ready", 32'(ready_o), 32'd1);
    expect_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    send(mk(F3_LH, 1'b1, 1'b0, 1'b1, 5'd14), 32'h0000_0103, 32'h0);
    @(negedge clk_i);
    check("mis_lh_no_req", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i);
`else
    // Misaligned accesses are aligned and proceed normally
    expect_wb(1'b1, 5'd13, 32'h1122_3344, 1'b0, 1'b1);
    mem_op("mis_lw", F3_LW, 1'b0, 5'd13, 32'h0000_0102, 32'h0, 32'h1122_3344, 1,
           32'h0000_0100, 4'b1111, 32'h0);
    expect_wb(1'b1, 5'd14, 32'hFFFF_A5B6, 1'b0, 1'b1);
    mem_op("mis_lh", F3_LH, 1'b0, 5'd14, 32'h0000_0103, 32'h0, 32'hA5B6_0102, 2,
           32'h0000_0100, 4'b1100, 32'h0);
`endif

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/memstage.md
MEMSTAGE -- requirements
Module: memstage

Interface
REQ-001 SHALL have parameter DMEM_TIMEOUT, default 255, meaning the number of WAIT cycles without acknowledge before the access is aborted (range 1..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all flops clocked on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port instruction_i  input  riscv_pkg::instruction_t  instruction leaving the execute stage.
REQ-005 SHALL have port result_i  input  32  ALU result, which is the memory address for loads and stores.
REQ-006 SHALL have port store_data_i  input  32  rs2 value carrying the store data.
REQ-007 SHALL have port valid_i  input  1  upstream instruction valid.
REQ-008 SHALL have port ready_o  output  1  stage can accept; low stalls upstream.
REQ-009 SHALL have ports dmem_req_o / dmem_we_o  output  1 each  data-memory request and write strobe.
REQ-010 SHALL have ports dmem_addr_o / dmem_wdata_o  output  32 each  word-aligned address and lane-replicated write data.
REQ-011 SHALL have port dmem_be_o  output  4  byte enables.
REQ-012 SHALL have ports dmem_ack_i  input  1 and dmem_rdata_i  input  32  memory acknowledge and read word.
REQ-013 SHALL have ports wb_valid_o  output  1, wb_we_o  output  1, wb_rd_o  output  5 and wb_data_o  output  32  writeback bundle.
REQ-014 SHALL have port error_o  output  1  one-cycle pulse on a timeout or on a misaligned access.

Function
REQ-015 SHALL accept an instruction in a cycle where valid_i and ready_o are both high, and ready_o SHALL be high exactly when the state is IDLE.
REQ-016 SHALL, for a non-memory instruction, register wb_data_o=result_i, wb_rd_o=rd, wb_we_o=reg_we and wb_valid_o=1 on the next edge (latency 1) and stay in IDLE.
REQ-017 SHALL, for a load or store, move to WAIT and on the next edge register dmem_req_o=1, dmem_we_o=is_store, dmem_addr_o={result_i[31:2],2'b00}, dmem_be_o and dmem_wdata_o.
REQ-018 SHALL generate stores per f3 as follows: SB gives be=1<<addr[1:0] with the byte replicated ×4; SH gives be=0011 or 1100 by addr[1] with the half replicated ×2; SW gives be=1111.
REQ-019 SHALL hold every dmem_* output stable in WAIT until dmem_ack_i is sampled high, and SHALL count an ack seen in the first WAIT cycle.
REQ-020 SHALL, on ack, deassert dmem_req_o, pulse wb_valid_o for 1 cycle and return to IDLE, so that the next acceptance is possible in the cycle after the ack.
REQ-021 SHALL extract the load lane by addr[1:0] and format it per f3: LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through; a store SHALL produce wb_we_o=0.
REQ-022 SHALL increment a WAIT cycle counter each cycle without ack; when it reaches DMEM_TIMEOUT the block SHALL drop dmem_req_o, pulse error_o and wb_valid_o with wb_we_o=0, and return to IDLE.
REQ-023 SHALL, when ack and timeout occur in the same cycle, complete the access normally with no error_o.
REQ-024 SHALL use exactly three states, IDLE, WAIT and RESP; RESP is entered only when MISALIGN_TRAP_EN is defined and lasts one cycle.
REQ-025 SHALL keep wb_valid_o and error_o low in every cycle that has no completing event.

Reset
REQ-026 SHALL, on rst_i high, immediately force state=IDLE, counter=0 and every output to 0 except ready_o, which SHALL be 1 once state=IDLE.
REQ-027 SHALL, when reset is asserted during WAIT, drop dmem_req_o asynchronously and discard the pending access, with no wb_valid_o after release.

Configuration
REQ-028 SHALL, with MISALIGN_TRAP_EN defined, send a halfword access with addr[0]=1 or a word access with addr[1:0]≠0 to RESP with no dmem_req_o, then pulse error_o and wb_valid_o with wb_we_o=0.
REQ-029 SHALL, with MISALIGN_TRAP_EN undefined, force the offending low address bits to zero and perform the access normally, leaving RESP unreachable.

Structure
REQ-030 SHALL extend instruction_t in riscv_pkg with the fields is_load, is_store, reg_we and rd[4:0], and riscv_pkg SHALL hold the f3 load/store encodings as named constants.
REQ-031 SHALL keep the state enum local to memstage.
REQ-032 SHALL implement load formatting as the combinational sub-module load_align, with inputs rdata, offset and f3 and output data.

Verification
REQ-033 SHALL cover: ADD with result_i=0x00000005 and rd=3 -> next cycle wb_valid_o=1, wb_data_o=0x5, wb_rd_o=3, wb_we_o=1, and no dmem_req_o.
REQ-034 SHALL cover: SB with addr=0x103 and data=0xAB -> dmem_addr_o=0x100, be=1000, wdata=0xABABABAB; ack after 3 cycles -> wb_valid_o=1, wb_we_o=0.
REQ-035 SHALL cover: LB with addr=0x102 and rdata=0x0080FF00 -> wb_data_o=0xFFFFFF80; LBU on the same word -> 0x00000080.
REQ-036 SHALL cover: LW with no ack and DMEM_TIMEOUT=4 -> req high for 4 cycles, then error_o pulse, ready_o=1.
REQ-037 SHALL cover: LW with ack in the same cycle as the timeout -> normal writeback and error_o=0; and rst_i asserted mid-WAIT -> dmem_req_o=0 at once and no wb_valid_o.
REQ-038 SHALL cover, with MISALIGN_TRAP_EN defined: LW at 0x102 -> no dmem_req_o, error_o pulse after 1 cycle; with it undefined -> dmem_addr_o=0x100 and a normal load.
